// File: rtl/nn_argmax.sv
// Arg-max back-end for the NN accelerator: snapshots the output-layer scores on a
// rising acc_ready edge, scans them one per cycle, and offers the winner via valid/rd_ack.
module nn_argmax #(
   parameter int NUM_CLASSES = 10,
   parameter int DATA_W      = 32
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          acc_ready,
   input  logic [NUM_CLASSES*DATA_W-1:0] results,
   input  logic                          rd_ack,
   output logic                          valid,
   output logic                          busy,
   output logic [3:0]                    digit,
   output logic [DATA_W-1:0]             max_val,
   output logic                          dropped
);

   localparam int IDX_W = $clog2(NUM_CLASSES);

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_e;

   state_e                    state_q, state_d;
   logic                      ready_q, ready_d;
   logic                      valid_q, valid_d;
   logic                      busy_q, busy_d;
   logic                      dropped_q, dropped_d;
   logic [3:0]                digit_q, digit_d;
   logic [DATA_W-1:0]         max_val_q, max_val_d;
   logic signed [DATA_W-1:0]  snap_q [NUM_CLASSES];
   logic signed [DATA_W-1:0]  snap_d [NUM_CLASSES];
   logic signed [DATA_W-1:0]  best_val_q, best_val_d;
   logic [IDX_W-1:0]          best_idx_q, best_idx_d;
   logic [IDX_W-1:0]          idx_q, idx_d;

   logic                      rise;
   logic                      start;
   logic                      better;
   logic signed [DATA_W-1:0]  next_best_val;
   logic [IDX_W-1:0]          next_best_idx;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d    = state_q;
      ready_d    = acc_ready;
      valid_d    = valid_q;
      busy_d     = busy_q;
      dropped_d  = dropped_q;
      digit_d    = digit_q;
      max_val_d  = max_val_q;
      snap_d     = snap_q;
      best_val_d = best_val_q;
      best_idx_d = best_idx_q;
      idx_d      = idx_q;
      start      = 1'b0;

      rise          = acc_ready & ~ready_q;
      better        = snap_q[idx_q] > best_val_q;
      next_best_val = better ? snap_q[idx_q] : best_val_q;
      next_best_idx = better ? idx_q : best_idx_q;

      if (rd_ack) dropped_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (rise) start = 1'b1;
         end
         ST_SCAN: begin
            // A new edge mid-scan is discarded; the snapshot stays as captured.
            if (rise) dropped_d = 1'b1;
            best_val_d = next_best_val;
            best_idx_d = next_best_idx;
            idx_d      = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_CLASSES - 1)) begin
               state_d   = ST_DONE;
               valid_d   = 1'b1;
               busy_d    = 1'b0;
               digit_d   = 4'(next_best_idx);
               max_val_d = next_best_val;
            end
         end
         ST_DONE: begin
            // Restart outranks an acknowledge arriving in the same cycle.
            if (rise) begin
               start = 1'b1;
            end else if (rd_ack) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (start) begin
         state_d = ST_SCAN;
         valid_d = 1'b0;
         busy_d  = 1'b1;
         for (int i = 0; i < NUM_CLASSES; i++) snap_d[i] = results[i*DATA_W +: DATA_W];
         best_val_d = results[DATA_W-1:0];
         best_idx_d = '0;
         idx_d      = IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         ready_q    <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         dropped_q  <= 1'b0;
         digit_q    <= '0;
         max_val_q  <= '0;
         best_val_q <= '0;
         best_idx_q <= '0;
         idx_q      <= '0;
         // NOTE: the snapshot is small register storage with a defined reset value, so it is reset here too.
         for (int i = 0; i < NUM_CLASSES; i++) snap_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_q    <= state_d;
         ready_q    <= ready_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         dropped_q  <= dropped_d;
         digit_q    <= digit_d;
         max_val_q  <= max_val_d;
         best_val_q <= best_val_d;
         best_idx_q <= best_idx_d;
         idx_q      <= idx_d;
         snap_q     <= snap_d;
      end
   end

   assign valid   = valid_q;
   assign busy    = busy_q;
   assign digit   = digit_q;
   assign max_val = max_val_q;
   assign dropped = dropped_q;

endmodule

// File: tb/tb_nn_argmax.sv
// Directed self-checking bench for nn_argmax with hand-computed expected results.
module tb_nn_argmax;

   localparam int NC = 10;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              resetn;
   logic              acc_ready;
   logic [NC*DW-1:0]  results;
   logic              rd_ack;
   logic              valid;
   logic              busy;
   logic [3:0]        digit;
   logic [DW-1:0]     max_val;
   logic              dropped;

   int n_tests = 0;
   int n_fail  = 0;

   nn_argmax #(.NUM_CLASSES(NC), .DATA_W(DW)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .acc_ready (acc_ready),
      .results   (results),
      .rd_ack    (rd_ack),
      .valid     (valid),
      .busy      (busy),
      .digit     (digit),
      .max_val   (max_val),
      .dropped   (dropped)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [NC*DW-1:0] pack(input int s [NC]);
      logic [NC*DW-1:0] r;
      for (int i = 0; i < NC; i++) r[i*DW +: DW] = s[i];
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},   valid,   0);
      check({tag, "_busy"},    busy,    0);
      check({tag, "_digit"},   digit,   0);
      check({tag, "_max_val"}, max_val, 0);
      check({tag, "_dropped"}, dropped, 0);
   endtask

   // Called right after the capture edge; optionally glitches acc_ready and results mid-scan.
   task automatic finish_scan(input string tag, input logic [3:0] exp_digit,
                              input logic [31:0] exp_val, input bit glitch,
                              input logic [NC*DW-1:0] alt);
      int busy_cnt;
      busy_cnt = (busy === 1'b1 && valid === 1'b0) ? 1 : 0;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (busy === 1'b1 && valid === 1'b0) busy_cnt++;
         if (glitch && i == 2) acc_ready = 1'b0;
         if (glitch && i == 3) begin
            acc_ready = 1'b1;
            results   = alt;
         end
      end
      step();
      check({tag, "_busy_cycles"}, busy_cnt, 9);
      check({tag, "_valid"},   valid,   1);
      check({tag, "_busy_end"}, busy,   0);
      check({tag, "_digit"},   digit,   exp_digit);
      check({tag, "_max_val"}, max_val, exp_val);
   endtask

   task automatic run_scan(input string tag, input logic [3:0] exp_digit, input logic [31:0] exp_val);
      step();
      check({tag, "_start_busy"},  busy,  1);
      check({tag, "_start_valid"}, valid, 0);
      finish_scan(tag, exp_digit, exp_val, 1'b0, '0);
   endtask

   task automatic start(input logic [NC*DW-1:0] vec);
      acc_ready = 1'b0;
      step();
      results   = vec;
      acc_ready = 1'b1;
   endtask

   task automatic pulse_ack();
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
   endtask

   initial begin
      int va [NC];
      int vb [NC];
      int vb2 [NC];
      int ve [NC];
      int vc [NC];
      int vd [NC];
      logic [NC*DW-1:0] pa, pb, pb2, pe, pc, pd, tmp;
      int busy_cnt;
      int valid_cnt;

      va  = '{5, -3, 12, 7, 0, 12, -100, 11, 2, 1};
      vb  = '{-9, -4, -7, -2, -8, -5, -6, -3, -10, -11};
      vb2 = vb;
      vb2[0] = 32'h8000_0000;
      for (int i = 0; i < NC; i++) ve[i] = 32'h8000_0000;
      vc  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
      vd  = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
      pa = pack(va);  pb = pack(vb);  pb2 = pack(vb2);
      pe = pack(ve);  pc = pack(vc);  pd = pack(vd);

      // Reset with acc_ready low: everything idle.
      resetn = 1'b0; acc_ready = 1'b0; rd_ack = 1'b0; results = '0;
      #3;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      step();
      check_all_zero("post_reset");

      // Basic scan with a tie between classes 2 and 5.
      start(pa);
      run_scan("tie", 4'd2, 32'd12);

      // All-negative scores, with and without the most negative value at class 0.
      start(pb);
      run_scan("neg", 4'd3, 32'hFFFF_FFFE);
      start(pb2);
      run_scan("minval", 4'd3, 32'hFFFF_FFFE);
      start(pe);
      run_scan("all_equal", 4'd0, 32'h8000_0000);
      start(pc);
      run_scan("last_wins", 4'd9, 32'd10);

      // Snapshot isolation: class 9 jumps to 99 right after capture.
      start(pa);
      step();
      tmp = pa;
      tmp[9*DW +: DW] = 32'd99;
      results = tmp;
      finish_scan("snap", 4'd2, 32'd12, 1'b0, '0);
      pulse_ack();
      check("ack_valid", valid, 0);
      check("ack_digit", digit, 2);
      check("ack_max_val", max_val, 12);

      // Re-raise acc_ready mid-scan: ignored, flagged as dropped.
      start(pb);
      step();
      finish_scan("drop", 4'd3, 32'hFFFF_FFFE, 1'b1, pa);
      check("drop_flag", dropped, 1);
      pulse_ack();
      check("drop_clear", dropped, 0);
      check("drop_ack_valid", valid, 0);

      // In DONE: rising edge and rd_ack together, restart wins.
      start(pa);
      run_scan("pre_restart", 4'd2, 32'd12);
      acc_ready = 1'b0;
      step();
      check("done_hold_valid", valid, 1);
      results = pc; acc_ready = 1'b1; rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      check("restart_valid", valid, 0);
      check("restart_busy",  busy,  1);
      check("restart_digit_hold", digit, 2);
      finish_scan("restart", 4'd9, 32'd10, 1'b0, '0);

      // Level held high must not retrigger.
      busy_cnt = 0; valid_cnt = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (busy !== 1'b0) busy_cnt++;
         if (valid === 1'b1) valid_cnt++;
      end
      check("hold_busy_cnt", busy_cnt, 0);
      check("hold_valid_cnt", valid_cnt, 50);

      // Asynchronous reset during scan cycle 4, then restart with acc_ready held high.
      start(pa);
      step();
      check("rst_scan_busy", busy, 1);
      repeat (3) step();
      resetn = 1'b0;
      #1;
      check_all_zero("async_rst");
      results = pd;
      @(posedge clk);
      #1 resetn = 1'b1;
      run_scan("rst_rescan", 4'd5, 32'd9);
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (busy !== 1'b0) busy_cnt++;
      end
      check("rst_single_scan", busy_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
